add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 127 ++++++++++++
 tb/tb_add_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Four-requester round-robin arbiter feeding a shared saturating adder.
// One transaction at a time: grant, capture sum, saturate, hold response until accepted.
module add_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  input  logic [NREQ-1:0]         sgn,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, CAPT, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             win_vld;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [1:0]       id_q;
  logic [WIDTH:0]   a_ext, b_ext;
  logic [WIDTH:0]   sum_q;
  logic [WIDTH-1:0] sat_data;
  logic             sat_ovf;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to ptr is the last (and therefore winning) assignment.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    cand    = ptr;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE: begin
        if (win_vld && !rst) begin
          gnt[win]  = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT:    state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (|gnt) ptr <= win + 2'd1;
    end
  end

  // NOTE: operand and sum registers are not reset; they are always written before any state that reads them.
  always_ff @(posedge clk) begin
    if (|gnt) begin
      a_q   <= op_a[int'(win)*WIDTH +: WIDTH];
      b_q   <= op_b[int'(win)*WIDTH +: WIDTH];
      sgn_q <= sgn[win];
      id_q  <= win;
    end
    if (state == CAPT) sum_q <= a_ext + b_ext;
  end

  assign a_ext = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
  assign b_ext = sgn_q ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};

  // Signed overflow shows as disagreement between the two top sum bits;
  // unsigned overflow as a carry into the extension bit.
  always_comb begin
    sat_data = sum_q[WIDTH-1:0];
    sat_ovf  = 1'b0;
    if (sgn_q) begin
      if (sum_q[WIDTH] != sum_q[WIDTH-1]) begin
        sat_ovf  = 1'b1;
        sat_data = sum_q[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else if (sum_q[WIDTH]) begin
      sat_ovf  = 1'b1;
      sat_data = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id   <= 2'd0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id   <= id_q;
      rsp_data <= sat_data;
      rsp_ovf  <= sat_ovf;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: table of single-requester adds plus
// hand-written fairness, backpressure and mid-operation reset sequences.
module tb_add_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   sgn;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ovf;
  logic           busy;

  int nvec = 0;
  int nerr = 0;

  add_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .sgn(sgn),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] ed;
    logic       eo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One full transaction; operands are scrambled right after the grant so
  // the response must come from the values sampled in the grant cycle.
  task automatic do_txn(input logic [1:0] idx, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] ed, input logic eo);
    int waited;
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    @(negedge clk);
    req       = onehot;
    op_a[int'(idx)*W +: W] = a;
    op_b[int'(idx)*W +: W] = b;
    sgn[idx]  = s;
    rsp_ready = 1'b1;
    #1;
    waited = 0;
    while (gnt == '0 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("txn_gnt", 32'(gnt), 32'(onehot));
    @(negedge clk);
    req  = '0;
    op_a = $urandom;
    op_b = $urandom;
    sgn  = ~sgn;
    #1;
    check("txn_busy", 32'(busy), 32'd1);
    check("txn_valid_early1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("txn_valid_early2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("txn_valid", 32'(rsp_valid), 32'd1);
    check("txn_id", 32'(rsp_id), 32'(idx));
    check("txn_data", 32'(rsp_data), 32'(ed));
    check("txn_ovf", 32'(rsp_ovf), 32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    vecs[0]  = '{2'd0, 8'h7F, 8'h01, 1'b1, 8'h7F, 1'b1};
    vecs[1]  = '{2'd2, 8'h80, 8'hFF, 1'b1, 8'h80, 1'b1};
    vecs[2]  = '{2'd3, 8'hF0, 8'h20, 1'b0, 8'hFF, 1'b1};
    vecs[3]  = '{2'd1, 8'h05, 8'hFD, 1'b1, 8'h02, 1'b0};
    vecs[4]  = '{2'd0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[5]  = '{2'd1, 8'h80, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[6]  = '{2'd2, 8'h40, 8'h40, 1'b1, 8'h7F, 1'b1};
    vecs[7]  = '{2'd3, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{2'd0, 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[9]  = '{2'd1, 8'hC0, 8'hC0, 1'b1, 8'h80, 1'b0};
    vecs[10] = '{2'd3, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};
    vecs[11] = '{2'd2, 8'h20, 8'h10, 1'b0, 8'h30, 1'b0};

    // Reset with all requests asserted: no grant, all outputs cleared.
    rst = 1'b1; req = 4'hF; op_a = '0; op_b = '0; sgn = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_state", {rsp_valid, busy, rsp_ovf, 1'b0, 2'b00, rsp_id, 16'd0, rsp_data},
          32'd0);
    @(negedge clk);
    rst = 1'b0; req = '0;

    foreach (vecs[i])
      do_txn(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ed, vecs[i].eo);

    // Fairness from a fresh reset: order 0,1,2,3,0 with 4-cycle spacing.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'hF; rsp_ready = 1'b1;
    n = 0; last = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      #1;
      if (gnt != '0) begin
        check("fair_order", 32'(gnt), 32'(4'b0001 << (n % 4)));
        if (n > 0) check("fair_gap", 32'(cyc - last), 32'd4);
        last = cyc;
        n++;
      end
      if (n < 5) @(negedge clk);
    end
    check("fair_count", 32'(n), 32'd5);
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Backpressure: requester 1 (ptr is 1), stall 10 cycles in RESP.
    req = 4'b0010; op_a[1*W +: W] = 8'h03; op_b[1*W +: W] = 8'h04; sgn[1] = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("bp_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    req = 4'hF;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_stall", {19'd0, gnt, rsp_valid, rsp_id, rsp_data},
            {19'd0, 4'b0000, 1'b1, 2'd1, 8'h07});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release", {19'd0, gnt, rsp_valid, rsp_id, rsp_data},
          {19'd0, 4'b0000, 1'b1, 2'd1, 8'h07});
    @(negedge clk);
    #1;
    check("bp_next_gnt", 32'(gnt), 32'h4);
    check("bp_next_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Reset while in EXEC discards the transaction.
    req = 4'b0100; op_a[2*W +: W] = 8'h11; op_b[2*W +: W] = 8'h22; sgn[2] = 1'b0;
    #1;
    check("mr_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mr_after", {29'd0, busy, rsp_valid, 1'b0}, 32'd0);
    check("mr_gnt_in_rst", 32'(gnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("mr_no_rsp", {30'd0, busy, rsp_valid}, 32'd0);
    end
    do_txn(2'd2, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
